if_fetch_unit: RTL and testbench

Instruction fetch stage that drives the producer side of the IF/ID pipeline register. It holds the program counter and issues instruction-memory requests over a req/ack handshake. It buffers each returned instruction until the IF/ID register accepts it, and discards in-flight fetches on a control-flow redirect. It sits between the instruction memory and the IF/ID register, and takes stall and redirect inputs from the hazard and branch logic.

---
 rtl/if_fetch_unit_if.sv | 23 ++
 rtl/if_fetch_unit.sv | 124 ++++++++++++
 tb/tb_if_fetch_unit.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory port of the fetch stage.
// Handshake: o_imem_req is held high with o_imem_addr stable until the cycle
// i_imem_ack is seen high; i_imem_rdata is valid in that same ack cycle.
interface if_fetch_unit_if;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_ack;
    logic [31:0] i_imem_rdata;

    modport master (
        output o_imem_req,
        output o_imem_addr,
        input  i_imem_ack,
        input  i_imem_rdata
    );

    modport slave (
        input  o_imem_req,
        input  o_imem_addr,
        output i_imem_ack,
        output i_imem_rdata
    );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over req/ack, buffers one
// instruction for the IF/ID register and drops in-flight fetches on redirect.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0000
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_stall,
    input  logic                   i_redirect,
    input  logic [31:0]            i_redirect_pc,
    if_fetch_unit_if.master        imem,
    output logic                   o_valid,
    output logic [31:0]            o_pc,
    output logic [31:0]            o_next_pc,
    output logic [31:0]            o_data,
    output logic [1:0]             o_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2,
        S_DROP  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] buf_pc_q, buf_pc_d;
    logic [31:0] buf_data_q, buf_data_d;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            addr_q     <= RESET_PC;
            buf_pc_q   <= 32'h0000_0000;
            buf_data_q <= NOP;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            addr_q     <= addr_d;
            buf_pc_q   <= buf_pc_d;
            buf_data_q <= buf_data_d;
        end
    end

    // Redirect wins over stall and ack. An unacked request cannot be
    // withdrawn, so a redirect in S_FETCH parks in S_DROP until it completes.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        addr_d     = addr_q;
        buf_pc_d   = buf_pc_q;
        buf_data_d = buf_data_q;

        unique case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
                if (i_redirect) begin
                    pc_d   = i_redirect_pc;
                    addr_d = i_redirect_pc;
                end else begin
                    addr_d = pc_q;
                end
            end

            S_FETCH: begin
                if (i_redirect) begin
                    pc_d = i_redirect_pc;
                    if (imem.i_imem_ack) begin
                        addr_d  = i_redirect_pc;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_DROP;
                    end
                end else if (imem.i_imem_ack) begin
                    buf_data_d = imem.i_imem_rdata;
                    buf_pc_d   = addr_q;
                    pc_d       = addr_q + 32'd4;
                    state_d    = S_HOLD;
                end
            end

            S_HOLD: begin
                if (i_redirect) begin
                    pc_d    = i_redirect_pc;
                    addr_d  = i_redirect_pc;
                    state_d = S_FETCH;
                end else if (!i_stall) begin
                    addr_d  = pc_q;
                    state_d = S_FETCH;
                end
            end

            S_DROP: begin
                if (i_redirect) begin
                    pc_d = i_redirect_pc;
                    if (imem.i_imem_ack) begin
                        addr_d  = i_redirect_pc;
                        state_d = S_FETCH;
                    end
                end else if (imem.i_imem_ack) begin
                    addr_d  = pc_q;
                    state_d = S_FETCH;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decode only registered state, so nothing from imem reaches o_*.
    assign imem.o_imem_req  = (state_q == S_FETCH) || (state_q == S_DROP);
    assign imem.o_imem_addr = addr_q;

    assign o_valid   = (state_q == S_HOLD);
    assign o_data    = o_valid ? buf_data_q : NOP;
    assign o_pc      = buf_pc_q;
    assign o_next_pc = buf_pc_q + 32'd4;
    assign o_state   = state_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: reset, fetch/hold/stall, delayed ack,
// redirects in every state, PC wrap and mid-run asynchronous reset.
module tb_if_fetch_unit;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
    localparam logic [1:0] S_DROP  = 2'd3;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] next_pc;
    logic [31:0] data;
    logic [1:0]  state;

    int passed = 0;
    int total  = 0;

    if_fetch_unit_if imem_if ();

    if_fetch_unit dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_stall       (stall),
        .i_redirect    (redirect),
        .i_redirect_pc (redirect_pc),
        .imem          (imem_if.master),
        .o_valid       (valid),
        .o_pc          (pc),
        .o_next_pc     (next_pc),
        .o_data        (data),
        .o_state       (state)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic check_out(input string tag, input logic [1:0] st, input logic req,
                             input logic [31:0] addr, input logic vld,
                             input logic [31:0] opc, input logic [31:0] odata);
        check({tag, ".state"}, {30'd0, state}, {30'd0, st});
        check({tag, ".req"},   {31'd0, imem_if.o_imem_req}, {31'd0, req});
        if (req) check({tag, ".addr"}, imem_if.o_imem_addr, addr);
        check({tag, ".valid"}, {31'd0, valid}, {31'd0, vld});
        check({tag, ".pc"},    pc, opc);
        check({tag, ".npc"},   next_pc, opc + 32'd4);
        check({tag, ".data"},  data, odata);
    endtask

    task automatic drive_mem(input logic ack, input logic [31:0] rdata);
        imem_if.i_imem_ack   = ack;
        imem_if.i_imem_rdata = rdata;
    endtask

    task automatic drive_redirect(input logic r, input logic [31:0] target);
        redirect    = r;
        redirect_pc = target;
    endtask

    initial begin
        rst_n = 1'b0;
        stall = 1'b0;
        drive_redirect(1'b0, 32'h0);
        drive_mem(1'b0, 32'h0);
        #12;
        check_out("reset", S_IDLE, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        rst_n = 1'b1;

        tick();
        check_out("first_req", S_FETCH, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);

        drive_mem(1'b1, 32'h2002_0001);
        tick();
        drive_mem(1'b0, 32'h0);
        check_out("first_valid", S_HOLD, 1'b0, 32'h0, 1'b1, 32'h0, 32'h2002_0001);

        tick();
        check_out("req_addr4", S_FETCH, 1'b1, 32'h4, 1'b0, 32'h0, 32'h0);

        drive_mem(1'b1, 32'h1111_0004);
        tick();
        drive_mem(1'b0, 32'h0);
        stall = 1'b1;
        check_out("hold_pc4", S_HOLD, 1'b0, 32'h0, 1'b1, 32'h4, 32'h1111_0004);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_out("stall_hold", S_HOLD, 1'b0, 32'h0, 1'b1, 32'h4, 32'h1111_0004);
        end
        stall = 1'b0;
        tick();
        check_out("req_addr8", S_FETCH, 1'b1, 32'h8, 1'b0, 32'h4, 32'h0);

        // stall is ignored while waiting on memory
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_out("wait_addr8", S_FETCH, 1'b1, 32'h8, 1'b0, 32'h4, 32'h0);
        end

        drive_redirect(1'b1, 32'h0000_0100);
        tick();
        drive_redirect(1'b0, 32'h0);
        check_out("drop_enter", S_DROP, 1'b1, 32'h8, 1'b0, 32'h4, 32'h0);
        tick();
        check_out("drop_wait", S_DROP, 1'b1, 32'h8, 1'b0, 32'h4, 32'h0);
        drive_mem(1'b1, 32'hDEAD_BEEF);
        tick();
        drive_mem(1'b0, 32'h0);
        check_out("drop_done", S_FETCH, 1'b1, 32'h100, 1'b0, 32'h4, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_out("wait_100", S_FETCH, 1'b1, 32'h100, 1'b0, 32'h4, 32'h0);
        end
        drive_mem(1'b1, 32'h0000_0113);
        tick();
        drive_mem(1'b0, 32'h0);
        check_out("hold_100", S_HOLD, 1'b0, 32'h0, 1'b1, 32'h100, 32'h0000_0113);
        tick();
        check_out("hold_100_stalled", S_HOLD, 1'b0, 32'h0, 1'b1, 32'h100, 32'h0000_0113);

        drive_redirect(1'b1, 32'h0000_0200);
        tick();
        drive_redirect(1'b0, 32'h0);
        stall = 1'b0;
        check_out("redir_hold", S_FETCH, 1'b1, 32'h200, 1'b0, 32'h100, 32'h0);

        drive_redirect(1'b1, 32'hFFFF_FFFC);
        drive_mem(1'b1, 32'hBAD0_0200);
        tick();
        drive_redirect(1'b0, 32'h0);
        drive_mem(1'b0, 32'h0);
        check_out("redir_ack", S_FETCH, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h100, 32'h0);

        drive_mem(1'b1, 32'h1234_5678);
        tick();
        drive_mem(1'b0, 32'h0);
        check_out("wrap_hold", S_HOLD, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 32'h1234_5678);
        check("wrap_npc_zero", next_pc, 32'h0);
        tick();
        check_out("wrap_req0", S_FETCH, 1'b1, 32'h0, 1'b0, 32'hFFFF_FFFC, 32'h0);

        // redirect twice while the abandoned request is still outstanding
        drive_redirect(1'b1, 32'h0000_0040);
        tick();
        check_out("drop2_enter", S_DROP, 1'b1, 32'h0, 1'b0, 32'hFFFF_FFFC, 32'h0);
        drive_redirect(1'b1, 32'h0000_0080);
        tick();
        drive_redirect(1'b0, 32'h0);
        check_out("drop2_retarget", S_DROP, 1'b1, 32'h0, 1'b0, 32'hFFFF_FFFC, 32'h0);
        drive_mem(1'b1, 32'hCAFE_0000);
        tick();
        drive_mem(1'b0, 32'h0);
        check_out("drop2_done", S_FETCH, 1'b1, 32'h80, 1'b0, 32'hFFFF_FFFC, 32'h0);

        // asynchronous reset mid-request, then redirect out of S_IDLE
        #2;
        rst_n = 1'b0;
        #1;
        check_out("async_reset", S_IDLE, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        #3;
        rst_n = 1'b1;
        drive_redirect(1'b1, 32'h0000_0300);
        tick();
        drive_redirect(1'b0, 32'h0);
        check_out("redir_idle", S_FETCH, 1'b1, 32'h300, 1'b0, 32'h0, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
